// File: rtl/axi_lite_master_seq.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI-Lite transaction out,
// one response back. Every AXI wait is bounded by P_TIMEOUT cycles.
module axi_lite_master_seq #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 16,
  parameter int unsigned P_TIMEOUT          = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  // command stream
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_rnw,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
  // response stream
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [P_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,
  output logic                          o_rsp_timeout,
  output logic                          o_busy,
  // AXI-Lite write channels
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  // AXI-Lite read channels
  output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int unsigned     CntW   = $clog2(P_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(P_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StResp
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;

  logic aw_fin;
  logic w_fin;
  logic advance;
  logic waiting;
  logic timeout_hit;

  // A write channel is finished once its valid has dropped or is handshaking now.
  assign aw_fin  = !m_axi_awvalid || m_axi_awready;
  assign w_fin   = !m_axi_wvalid || m_axi_wready;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    advance = 1'b0;
    waiting = 1'b1;
    unique case (state_q)
      StWrAddrData: advance = aw_fin && w_fin;
      StWrResp:     advance = m_axi_bvalid;
      StRdAddr:     advance = m_axi_arready;
      StRdData:     advance = m_axi_rvalid;
      default:      waiting = 1'b0;
    endcase
  end

  // A handshake landing on the threshold cycle takes priority over the abort.
  assign timeout_hit = waiting && !advance && (cnt_q == CntMax);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      o_cmd_ready   <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_resp    <= 2'b00;
      o_rsp_timeout <= 1'b0;
      o_busy        <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else if (timeout_hit) begin
      // Abort: withdraw every valid/ready so a late beat is never accepted.
      state_q       <= StResp;
      cnt_q         <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      o_rsp_valid   <= 1'b1;
      o_rsp_resp    <= 2'b10;
      o_rsp_timeout <= 1'b1;
      o_rsp_rdata   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          o_cmd_ready <= 1'b1;
          if (o_cmd_ready && i_cmd_valid) begin
            o_cmd_ready   <= 1'b0;
            o_busy        <= 1'b1;
            o_rsp_timeout <= 1'b0;
            cnt_q         <= '0;
            if (i_cmd_rnw) begin
              m_axi_araddr  <= i_cmd_addr;
              m_axi_arvalid <= 1'b1;
              state_q       <= StRdAddr;
            end else begin
              m_axi_awaddr  <= i_cmd_addr;
              m_axi_wdata   <= i_cmd_wdata;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state_q       <= StWrAddrData;
            end
          end
        end

        StWrAddrData: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (advance) begin
            m_axi_bready <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StWrResp;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StWrResp: begin
          if (advance) begin
            m_axi_bready  <= 1'b0;
            o_rsp_resp    <= m_axi_bresp;
            o_rsp_rdata   <= '0;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            cnt_q         <= '0;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StRdAddr: begin
          if (advance) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            cnt_q         <= '0;
            state_q       <= StRdData;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StRdData: begin
          if (advance) begin
            m_axi_rready  <= 1'b0;
            o_rsp_rdata   <= m_axi_rdata;
            o_rsp_resp    <= m_axi_rresp;
            o_rsp_timeout <= 1'b0;
            o_rsp_valid   <= 1'b1;
            cnt_q         <= '0;
            state_q       <= StResp;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StResp: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_busy      <= 1'b0;
            o_cmd_ready <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
